// File: rtl/scaler_pkg.sv
// Shared widths, types and helpers for the vertical scaler.
package scaler_pkg;

  localparam int unsigned STEP_ONE = 4096;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned LIN_W    = 12;
  localparam int unsigned COE_W    = 8;
  localparam int unsigned PIX_W    = 8;

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [LIN_W-1:0] lin_t;
  typedef logic [COE_W-1:0] coe_t;
  typedef logic [PIX_W-1:0] pix_t;

  // Upscaling is not supported, so any step below 1.000 is treated as 1.000.
  function automatic logic [15:0] clamp_step(input logic [15:0] s, input logic [15:0] one);
    return (s < one) ? one : s;
  endfunction

endpackage

// File: rtl/scaler_v_linebuf.sv
// One-line pixel store: simple dual-port RAM, 1-clock read, read-first on collision.
module scaler_v_linebuf #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/scaler_v.sv
// Vertical linear-interpolation downscaler: blends the stored previous line with
// the current one using a 12.12 line-position accumulator.
module scaler_v
  import scaler_pkg::*;
#(
  parameter int unsigned PIXEL_STEP    = STEP_ONE,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LINE_SIZE_MAX = 4096,
  parameter int unsigned COE_WIDTH     = COE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           scale_step,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int unsigned AW   = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
  localparam int unsigned XW   = AW + 1;
  localparam int unsigned FRAC = 12;
  localparam int unsigned PW   = DATA_WIDTH + COE_WIDTH;

  localparam logic [COE_WIDTH:0] W_ONE = {1'b1, {COE_WIDTH{1'b0}}};
  localparam logic [PW:0]        RND   = {{(PW+1-COE_WIDTH){1'b0}}, 1'b1, {(COE_WIDTH-1){1'b0}}};

  logic [15:0]          step_q;
  acc_t                 acc;
  lin_t                 lin;
  logic [XW-1:0]        x;
  logic                 hs_q;
  logic                 emit_q;
  logic [COE_WIDTH-1:0] coe_q;

  logic                 line_start, line_end;
  logic                 emit_calc, emit_now;
  logic [COE_WIDTH-1:0] coe_now;
  logic                 x_ok, pix_v;

  assign line_start = hs_q & ~hs_i;
  assign line_end   = ~hs_q & hs_i;
  assign emit_calc  = (lin != '0) && (acc[ACC_W-1:FRAC] == lin - lin_t'(1));
  // The decision is also used combinationally so a pixel on the same cycle as
  // the hs falling edge already sees this line's emit/coe.
  assign emit_now   = line_start ? emit_calc : emit_q;
  assign coe_now    = line_start ? acc[FRAC-1 -: COE_WIDTH] : coe_q;
  assign x_ok       = x < XW'(LINE_SIZE_MAX);
  assign pix_v      = de_i & ~hs_i & x_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= 16'(PIXEL_STEP);
      acc    <= '0;
      lin    <= '0;
      x      <= '0;
      hs_q   <= 1'b1;
      emit_q <= 1'b0;
      coe_q  <= '0;
    end else begin
      hs_q <= hs_i;
      // x is one bit wider than the RAM address and saturates, so overlong
      // lines never wrap back into the buffer.
      if (hs_i)
        x <= '0;
      else if (de_i && x != '1)
        x <= x + XW'(1);

      if (vs_i) begin
        step_q <= clamp_step(scale_step, 16'(PIXEL_STEP));
        acc    <= '0;
        lin    <= '0;
        emit_q <= 1'b0;
        coe_q  <= '0;
      end else begin
        if (line_start) begin
          emit_q <= emit_calc;
          coe_q  <= coe_now;
        end
        if (line_end) begin
          if (emit_q) acc <= acc + acc_t'(step_q);
          if (lin != '1) lin <= lin + lin_t'(1);
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] prev;

  scaler_v_linebuf #(
    .DEPTH (LINE_SIZE_MAX),
    .DW    (DATA_WIDTH),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (pix_v),
    .waddr (x[AW-1:0]),
    .wdata (di_i),
    .re    (pix_v),
    .raddr (x[AW-1:0]),
    .rdata (prev)
  );

  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] cur1;
  logic [COE_WIDTH-1:0]  coe1;
  logic [COE_WIDTH:0]    w_prev;
  logic [PW-1:0]         p_prev, p_cur;
  logic [PW:0]           sum;
  logic [2:0]            hs_d, vs_d;

  assign w_prev = W_ONE - {1'b0, coe1};
  assign sum    = {1'b0, p_prev} + {1'b0, p_cur} + RND;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      cur1   <= '0;
      coe1   <= '0;
      p_prev <= '0;
      p_cur  <= '0;
      do_o   <= '0;
      de_o   <= 1'b0;
      hs_d   <= '1;
      vs_d   <= '1;
    end else begin
      v1     <= pix_v & emit_now;
      cur1   <= di_i;
      coe1   <= coe_now;
      v2     <= v1;
      p_prev <= PW'(prev) * PW'(w_prev);
      p_cur  <= PW'(cur1) * PW'(coe1);
      de_o   <= v2;
      do_o   <= DATA_WIDTH'(sum >> COE_WIDTH);
      hs_d   <= {hs_d[1:0], hs_i};
      vs_d   <= {vs_d[1:0], vs_i};
    end
  end

  assign hs_o = hs_d[2];
  assign vs_o = vs_d[2];

endmodule
